// File: rtl/lfsr.sv
// Maximal-length Fibonacci LFSR (shift left) with an optional de Bruijn mode
// that splices the all-zero state into the cycle. Advances only when ce=1.
module lfsr #(
    parameter int             WID  = 16,
    parameter logic [WID-1:0] INIT = {{(WID-1){1'b0}}, 1'b1}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           cyc,
    output logic [WID-1:0] o
);

    if (WID < 3 || WID > 64) begin : g_bad_wid
        $error("lfsr: WID must be in the range 3..64");
    end

    // Builds a tap mask from 1-based tap positions; zero means "no tap".
    function automatic logic [63:0] tp(input int a, input int b, input int c = 0,
                                       input int d = 0, input int e = 0, input int f = 0);
        logic [63:0] m;
        m = '0;
        if (a != 0) m[a-1] = 1'b1;
        if (b != 0) m[b-1] = 1'b1;
        if (c != 0) m[c-1] = 1'b1;
        if (d != 0) m[d-1] = 1'b1;
        if (e != 0) m[e-1] = 1'b1;
        if (f != 0) m[f-1] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] tap_mask(input int w);
        logic [63:0] m;
        m = '0;
        case (w)
            3:  m = tp(3, 2);
            4:  m = tp(4, 3);
            5:  m = tp(5, 3);
            6:  m = tp(6, 5);
            7:  m = tp(7, 6);
            8:  m = tp(8, 6, 5, 4);
            9:  m = tp(9, 5);
            10: m = tp(10, 7);
            11: m = tp(11, 9);
            12: m = tp(12, 6, 4, 1);
            13: m = tp(13, 4, 3, 1);
            14: m = tp(14, 5, 3, 1);
            15: m = tp(15, 14);
            16: m = tp(16, 15, 13, 4);
            17: m = tp(17, 14);
            18: m = tp(18, 11);
            19: m = tp(19, 6, 2, 1);
            20: m = tp(20, 17);
            21: m = tp(21, 19);
            22: m = tp(22, 21);
            23: m = tp(23, 18);
            24: m = tp(24, 23, 22, 17);
            25: m = tp(25, 22);
            26: m = tp(26, 6, 2, 1);
            27: m = tp(27, 5, 2, 1);
            28: m = tp(28, 25);
            29: m = tp(29, 27);
            30: m = tp(30, 6, 4, 1);
            31: m = tp(31, 28);
            32: m = tp(32, 22, 2, 1);
            33: m = tp(33, 20);
            34: m = tp(34, 27, 2, 1);
            35: m = tp(35, 33);
            36: m = tp(36, 25);
            37: m = tp(37, 5, 4, 3, 2, 1);
            38: m = tp(38, 6, 5, 1);
            39: m = tp(39, 35);
            40: m = tp(40, 38, 21, 19);
            41: m = tp(41, 38);
            42: m = tp(42, 41, 20, 19);
            43: m = tp(43, 42, 38, 37);
            44: m = tp(44, 43, 18, 17);
            45: m = tp(45, 44, 42, 41);
            46: m = tp(46, 45, 26, 25);
            47: m = tp(47, 42);
            48: m = tp(48, 47, 21, 20);
            49: m = tp(49, 40);
            50: m = tp(50, 49, 24, 23);
            51: m = tp(51, 50, 36, 35);
            52: m = tp(52, 49);
            53: m = tp(53, 52, 38, 37);
            54: m = tp(54, 53, 18, 17);
            55: m = tp(55, 31);
            56: m = tp(56, 55, 35, 34);
            57: m = tp(57, 50);
            58: m = tp(58, 39);
            59: m = tp(59, 58, 38, 37);
            60: m = tp(60, 59);
            61: m = tp(61, 60, 46, 45);
            62: m = tp(62, 61, 6, 5);
            63: m = tp(63, 62);
            64: m = tp(64, 63, 61, 60);
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [WID-1:0] TAP_BITS = WID'(tap_mask(WID));

    logic [WID-1:0] o_reg;
    logic [WID-1:0] o_next;
    logic [WID-1:0] tapped;
    logic           fb;

    for (genvar gi = 0; gi < WID; gi++) begin : g_tap
        assign tapped[gi] = o_reg[gi] & TAP_BITS[gi];
    end

    // De Bruijn mode flips the feedback when the low WID-1 bits are zero, which
    // routes 100..0 -> 0 and 0 -> 0..01; plain mode only rescues the zero state.
    always_comb begin
        fb = ^tapped;
        if (cyc) begin
            fb = fb ^ (o_reg[WID-2:0] == '0);
        end else if (o_reg == '0) begin
            fb = 1'b1;
        end
        o_next = {o_reg[WID-2:0], fb};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_reg <= INIT;
        end else if (ce) begin
            o_reg <= o_next;
        end
    end

    assign o = o_reg;

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr: several widths run side by side against a
// tap-list reference model, plus directed period, reset and mode checks.
module tb_lfsr;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce  = 1'b0;
    logic cyc = 1'b0;

    logic [21:0] o22;
    logic [3:0]  o4, o4z;
    logic [2:0]  o3;
    logic [7:0]  o8;
    logic [15:0] o16;
    logic [31:0] o32;
    logic [63:0] o64;

    always #5 clk = ~clk;

    lfsr #(.WID(22), .INIT(22'h0ACE3)) u22 (.clk(clk), .rst(rst), .ce(ce), .cyc(cyc), .o(o22));
    lfsr #(.WID(4),  .INIT(4'h1))      u4  (.clk(clk), .rst(rst), .ce(ce), .cyc(cyc), .o(o4));
    lfsr #(.WID(4),  .INIT(4'h0))      u4z (.clk(clk), .rst(rst), .ce(ce), .cyc(cyc), .o(o4z));
    lfsr #(.WID(3))                    u3  (.clk(clk), .rst(rst), .ce(ce), .cyc(cyc), .o(o3));
    lfsr #(.WID(8))                    u8  (.clk(clk), .rst(rst), .ce(ce), .cyc(cyc), .o(o8));
    lfsr #(.WID(16))                   u16 (.clk(clk), .rst(rst), .ce(ce), .cyc(cyc), .o(o16));
    lfsr #(.WID(32))                   u32 (.clk(clk), .rst(rst), .ce(ce), .cyc(cyc), .o(o32));
    lfsr #(.WID(64))                   u64 (.clk(clk), .rst(rst), .ce(ce), .cyc(cyc), .o(o64));

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: width, seed and published tap positions per instance.
    int          wid  [8] = '{22, 4, 4, 3, 8, 16, 32, 64};
    logic [63:0] init [8] = '{64'h0ACE3, 64'h1, 64'h0, 64'h1, 64'h1, 64'h1, 64'h1, 64'h1};
    int          taps [8][4] = '{'{22, 21, 0, 0}, '{4, 3, 0, 0}, '{4, 3, 0, 0}, '{3, 2, 0, 0},
                                 '{8, 6, 5, 4}, '{16, 15, 13, 4}, '{32, 22, 2, 1},
                                 '{64, 63, 61, 60}};
    logic [63:0] m [8];

    typedef struct {
        bit          r;
        bit          c;
        bit          y;
        logic [21:0] exp;
    } vec_t;
    vec_t vec [17];

    function automatic logic [63:0] model_next(input int i, input logic [63:0] s, input bit y);
        int          w = wid[i];
        logic [63:0] mask;
        bit          fb;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (s == 64'd0) return 64'd1;
        if (y && s == (64'd1 << (w - 1))) return 64'd0;
        fb = 1'b0;
        for (int k = 0; k < 4; k++)
            if (taps[i][k] != 0) fb = fb ^ s[taps[i][k] - 1];
        return ((s << 1) | {63'd0, fb}) & mask;
    endfunction

    function automatic logic [63:0] get_act(input int i);
        case (i)
            0: return {42'd0, o22};
            1: return {60'd0, o4};
            2: return {60'd0, o4z};
            3: return {61'd0, o3};
            4: return {56'd0, o8};
            5: return {48'd0, o16};
            6: return {32'd0, o32};
            default: return o64;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock edge with the given controls; model advances in lockstep.
    task automatic step(input bit r, input bit c, input bit y);
        rst = r;
        ce  = c;
        cyc = y;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (!r)     m[i] = init[i];
            else if (c) m[i] = model_next(i, m[i], y);
        end
        #1;
        $display("step t=%0t rst=%0b ce=%0b cyc=%0b o22=%h o4=%h o16=%h o64=%h",
                 $time, r, c, y, o22, o4, o16, o64);
        for (int i = 0; i < 8; i++)
            chk($sformatf("model_inst%0d", i), get_act(i), m[i]);
    endtask

    initial begin
        logic [15:0] seen;
        int          distinct, returns, zeros, trans_ok;
        logic [3:0]  prev;
        logic [15:0] rec16 [5];
        logic [21:0] rec22 [5];
        logic [3:0]  cov_dut [8];
        logic [3:0]  cov_ref [8];
        logic [63:0] a;
        bit          y_r;

        for (int i = 0; i < 8; i++) m[i] = '0;

        // Directed WID=22 vectors: reset, hold with ce=0, then six steps.
        vec[0] = '{1'b0, 1'b0, 1'b0, 22'h0ACE3};
        for (int i = 1; i <= 10; i++) vec[i] = '{1'b1, 1'b0, (i % 2) == 1, 22'h0ACE3};
        vec[11] = '{1'b1, 1'b1, 1'b0, 22'h159C6};
        vec[12] = '{1'b1, 1'b1, 1'b0, 22'h2B38C};
        vec[13] = '{1'b1, 1'b1, 1'b0, 22'h56718};
        vec[14] = '{1'b1, 1'b1, 1'b0, 22'hACE30};
        vec[15] = '{1'b1, 1'b1, 1'b0, 22'h159C60};
        vec[16] = '{1'b1, 1'b1, 1'b0, 22'h2B38C1};
        for (int i = 0; i < 17; i++) begin
            step(vec[i].r, vec[i].c, vec[i].y);
            chk($sformatf("wid22_vec%0d", i), {42'd0, o22}, {42'd0, vec[i].exp});
        end

        // WID=4 plain mode: reset (with ce=1, reset wins), then one full period.
        step(1'b0, 1'b1, 1'b0);
        chk("wid4_reset_over_ce", {60'd0, o4}, 64'h1);
        chk("wid4z_reset", {60'd0, o4z}, 64'h0);
        seen = '0; distinct = 0; returns = 0; zeros = 0;
        for (int k = 0; k < 15; k++) begin
            step(1'b1, 1'b1, 1'b0);
            if (k == 0) chk("wid4z_lockup_escape", {60'd0, o4z}, 64'h1);
            if (k == 1) chk("wid4z_after_escape", {60'd0, o4z}, 64'h2);
            if (!seen[o4]) distinct++;
            seen[o4] = 1'b1;
            if (o4 == 4'h1) returns++;
            if (o4 == 4'h0) zeros++;
        end
        chk("wid4_period15_distinct", 64'(distinct), 64'd15);
        chk("wid4_period15_return_once", 64'(returns), 64'd1);
        chk("wid4_period15_no_zero", 64'(zeros), 64'd0);
        chk("wid4_period15_back_to_seed", {60'd0, o4}, 64'h1);

        // WID=4 de Bruijn mode: 16 states, 8 -> 0 -> 1 splice.
        step(1'b0, 1'b0, 1'b1);
        seen = '0; distinct = 0; returns = 0; trans_ok = 0;
        prev = o4;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b1, 1'b1);
            if (!seen[o4]) distinct++;
            seen[o4] = 1'b1;
            if (o4 == 4'h1) returns++;
            if ((prev == 4'h8 && o4 == 4'h0) || (prev == 4'h0 && o4 == 4'h1)) trans_ok++;
            prev = o4;
        end
        chk("wid4_debruijn_distinct", 64'(distinct), 64'd16);
        chk("wid4_debruijn_return_once", 64'(returns), 64'd1);
        chk("wid4_debruijn_splice", 64'(trans_ok), 64'd2);

        // Mid-sequence reset with ce=1 restarts the identical sequence.
        step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0);
            rec16[k] = o16;
            rec22[k] = o22;
        end
        step(1'b0, 1'b1, 1'b0);
        chk("midreset_wid16", {48'd0, o16}, 64'h1);
        chk("midreset_wid22", {42'd0, o22}, 64'h0ACE3);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk($sformatf("restart_wid16_%0d", k), {48'd0, o16}, {48'd0, rec16[k]});
            chk($sformatf("restart_wid22_%0d", k), {42'd0, o22}, {42'd0, rec22[k]});
        end

        // Low-bit coverage over 16 steps after reset.
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cov_dut[i] = '0;
            cov_ref[i] = '0;
        end
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 8; i++) begin
                a = get_act(i);
                cov_dut[i][a[1:0]] = 1'b1;
                cov_ref[i][m[i][1:0]] = 1'b1;
            end
        end
        chk("lowbits_cov_wid3", {60'd0, cov_dut[3]}, 64'hF);
        chk("lowbits_cov_wid4", {60'd0, cov_dut[1]}, 64'hF);
        for (int i = 4; i < 8; i++)
            chk($sformatf("lowbits_cov_inst%0d", i), {60'd0, cov_dut[i]}, {60'd0, cov_ref[i]});

        // Random ce, occasional mode flips and resets, checked every cycle.
        y_r = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 15) == 0) y_r = ~y_r;
            step(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), y_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
